// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions for the host receive/transmit pair.
//   rx_state_e     : receiver FSM encoding
//   PS2_FRAME_BITS : start + 8 data + parity + stop
//   PS2_*          : common device response bytes
//   odd_parity_ok  : 1 when data plus parity bit has an odd number of ones
package ps2_pkg;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_e;

  localparam int PS2_FRAME_BITS = 11;

  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_BAT_OK = 8'hAA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ERROR  = 8'hFC;

  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Synchronizes the raw PS/2 clock and data lines into the clk domain and
// produces a registered falling-edge strobe for the PS/2 clock.
//   clk, rst     : system clock, synchronous active-high reset
//   ps2_clk_i    : raw PS/2 clock line (asynchronous)
//   ps2_data_i   : raw PS/2 data line (asynchronous)
//   data_sync_o  : synchronized data line
//   clk_fe_o     : one-cycle strobe, registered after sync clock went 1 -> 0
module ps2_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic data_sync_o,
  output logic clk_fe_o
);

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   clk_prev_q;
  logic                   clk_fe_q;

  // Preset to 1 so a reset never looks like a falling edge on an idle bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
      clk_fe_q    <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
      clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
      clk_fe_q    <= clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
    end
  end

  assign data_sync_o = data_sync_q[SYNC_STAGES-1];
  assign clk_fe_o    = clk_fe_q;

endmodule

// File: rtl/ps2_host_rx.sv
// Device-to-host PS/2 frame receiver (start 0, 8 data LSB first, odd parity,
// stop 1). Good bytes are delivered with a one-cycle rx_valid strobe.
//   clk, rst        : system clock, synchronous active-high reset
//   ps2_clk_in      : raw PS/2 clock line
//   ps2_data_in     : raw PS/2 data line
//   rx_en           : receive enable, low while host transmit owns the bus
//   rx_data         : last correctly received byte
//   rx_valid        : pulse, rx_data just updated
//   rx_parity_err   : pulse, parity mismatch (byte discarded)
//   rx_frame_err    : pulse, bad stop bit or inter-edge watchdog expiry
//   rx_busy         : frame in progress
module ps2_host_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_BITS = 13,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  input  logic       rx_en,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_parity_err,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  logic fe;
  logic d;

  ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk_i  (ps2_clk_in),
    .ps2_data_i (ps2_data_in),
    .data_sync_o(d),
    .clk_fe_o   (fe)
  );

  rx_state_e               state_q;
  logic [7:0]              shreg_q;
  logic [7:0]              data_q;
  logic [2:0]              bit_cnt_q;
  logic                    par_q;
  logic [TIMEOUT_BITS-1:0] wd_q;
  logic                    valid_q;
  logic                    perr_q;
  logic                    ferr_q;
  logic                    ok_par;

  assign ok_par = odd_parity_ok(shreg_q, par_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RX_IDLE;
      shreg_q   <= '0;
      data_q    <= '0;
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
      wd_q      <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          if (fe && !d && rx_en) begin
            state_q   <= RX_DATA;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            wd_q      <= '1;
          end
        end
        default: begin
          if (!rx_en) begin
            // Host transmit took the bus: drop the frame silently.
            state_q <= RX_IDLE;
          end else if (fe) begin
            // An edge always reloads, even if the watchdog was about to fire.
            wd_q <= '1;
            case (state_q)
              RX_DATA: begin
                shreg_q   <= {d, shreg_q[7:1]};
                bit_cnt_q <= bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) state_q <= RX_PARITY;
              end
              RX_PARITY: begin
                par_q   <= d;
                state_q <= RX_STOP;
              end
              default: begin
                if (ok_par && d) begin
                  data_q  <= shreg_q;
                  valid_q <= 1'b1;
                end
                perr_q  <= !ok_par;
                ferr_q  <= !d;
                state_q <= RX_IDLE;
              end
            endcase
          end else if (wd_q == TIMEOUT_BITS'(1)) begin
            // Counter would hit zero this cycle: device clock has stalled.
            ferr_q  <= 1'b1;
            state_q <= RX_IDLE;
          end else begin
            wd_q <= wd_q - 1'b1;
          end
        end
      endcase
    end
  end

  assign rx_data       = data_q;
  assign rx_valid      = valid_q;
  assign rx_parity_err = perr_q;
  assign rx_frame_err  = ferr_q;
  assign rx_busy       = (state_q != RX_IDLE);

endmodule
